// File: rtl/cnt_checker_pkg.sv
// Shared types and defaults for the counter checker: FSM state encoding,
// the bundle of observed counter controls, and parameter defaults.
package cnt_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Observed control strobes of the counter under check, in priority order.
  typedef struct packed {
    logic dut_rst;
    logic load;
    logic en;
    logic up;
  } ctrl_t;

  localparam int unsigned WIDTH_DEFAULT = 4;
  localparam int unsigned ERR_W_DEFAULT = 8;

endpackage : cnt_chk_pkg

// File: rtl/cnt_checker_if.sv
// Observation bus of the counter under check: its controls, load value and
// output. The master side drives the counter; the checker listens as slave.
interface cnt_checker_if #(
  parameter int WIDTH = 4
) ();

  logic             dut_rst;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] count_in;
  logic [WIDTH-1:0] count;

  modport master (
    output dut_rst, en, up, load, count_in, count
  );

  modport slave (
    input dut_rst, en, up, load, count_in, count
  );

endinterface : cnt_checker_if

// File: rtl/cnt_checker_model.sv
// Golden next-value rule for an up/down counter with synchronous reset and
// parallel load. Purely combinational so it can be reused as a reference.
module cnt_model
  import cnt_chk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  ctrl_t            ctrl,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] nxt
);

  // Reset beats load, load beats counting; arithmetic wraps modulo 2^WIDTH.
  always_comb begin
    // NOTE: nxt gets a value on every path (default first), so no latch is inferred.
    nxt = cur;
    if (ctrl.dut_rst) begin
      nxt = '0;
    end else if (ctrl.load) begin
      nxt = load_val;
    end else if (ctrl.en && ctrl.up) begin
      nxt = cur + 1'b1;
    end else if (ctrl.en) begin
      nxt = cur - 1'b1;
    end
  end

endmodule : cnt_model

// File: rtl/cnt_checker.sv
// Scoreboard for an up/down counter: syncs a predictor to the observed value,
// then flags every cycle where the observed count departs from the prediction.
module cnt_checker
  import cnt_chk_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int ERR_W = ERR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               stop,
  cnt_checker_if.slave       obs,
  output logic [WIDTH-1:0]   exp_count,
  output logic               error,
  output logic               err_sticky,
  output logic [ERR_W-1:0]   err_count,
  output logic [WIDTH-1:0]   first_exp,
  output logic [WIDTH-1:0]   first_obs,
  output logic               checking
);

  state_e             state_q,      state_d;
  logic [WIDTH-1:0]   exp_q,        exp_d;
  logic               error_q,      error_d;
  logic               sticky_q,     sticky_d;
  logic [ERR_W-1:0]   err_cnt_q,    err_cnt_d;
  logic [WIDTH-1:0]   first_exp_q,  first_exp_d;
  logic [WIDTH-1:0]   first_obs_q,  first_obs_d;
  logic               checking_q,   checking_d;

  ctrl_t            ctrl;
  logic [WIDTH-1:0] model_cur;
  logic [WIDTH-1:0] model_nxt;
  logic             mismatch;

  assign ctrl = '{dut_rst: obs.dut_rst, load: obs.load, en: obs.en, up: obs.up};

  // In SYNC the predictor is seeded from the observed count, afterwards it
  // runs free on its own prediction.
  assign model_cur = (state_q == SYNC) ? obs.count : exp_q;
  assign mismatch  = (obs.count != exp_q);

  cnt_model #(.WIDTH(WIDTH)) u_model (
    .ctrl     (ctrl),
    .cur      (model_cur),
    .load_val (obs.count_in),
    .nxt      (model_nxt)
  );

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    error_d     = 1'b0;
    sticky_d    = sticky_q;
    err_cnt_d   = err_cnt_q;
    first_exp_d = first_exp_q;
    first_obs_d = first_obs_q;

    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d     = SYNC;
          sticky_d    = 1'b0;
          err_cnt_d   = '0;
          first_exp_d = '0;
          first_obs_d = '0;
        end
      end
      SYNC: begin
        exp_d   = model_nxt;
        state_d = stop ? IDLE : CHECK;
      end
      CHECK: begin
        // The comparison on a stopping edge still counts.
        if (mismatch) begin
          error_d  = 1'b1;
          sticky_d = 1'b1;
          if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
          if (!sticky_q) begin
            first_exp_d = exp_q;
            first_obs_d = obs.count;
          end
        end
        exp_d = model_nxt;
        if (stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    checking_d = (state_d == CHECK);
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q     <= IDLE;
      exp_q       <= '0;
      error_q     <= 1'b0;
      sticky_q    <= 1'b0;
      err_cnt_q   <= '0;
      first_exp_q <= '0;
      first_obs_q <= '0;
      checking_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      error_q     <= error_d;
      sticky_q    <= sticky_d;
      err_cnt_q   <= err_cnt_d;
      first_exp_q <= first_exp_d;
      first_obs_q <= first_obs_d;
      checking_q  <= checking_d;
    end
  end

  assign exp_count  = exp_q;
  assign error      = error_q;
  assign err_sticky = sticky_q;
  assign err_count  = err_cnt_q;
  assign first_exp  = first_exp_q;
  assign first_obs  = first_obs_q;
  assign checking   = checking_q;

endmodule : cnt_checker

// File: doc/cnt_checker.md
CNT_CHECKER -- requirements
Module: cnt_checker

Interface
REQ-001 Parameter WIDTH, default 4: counter width checked.
REQ-002 Parameter ERR_W, default 8: error-counter width.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 arm  input  1  request to start checking; ignored unless in IDLE.
REQ-006 stop  input  1  return to IDLE; no further checks.
REQ-007 dut_rst  input  1  observed active-high synchronous reset of the counter under check.
REQ-008 en  input  1  observed counter enable.
REQ-009 up  input  1  observed direction; 1 = up, 0 = down.
REQ-010 load  input  1  observed parallel-load strobe.
REQ-011 count_in  input  WIDTH  observed load value.
REQ-012 count  input  WIDTH  observed counter output.
REQ-013 exp_count  output  WIDTH  predicted counter value for the current cycle.
REQ-014 error  output  1  one-cycle pulse per detected mismatch.
REQ-015 err_sticky  output  1  set on first mismatch; held until reset or arm.
REQ-016 err_count  output  ERR_W  saturating mismatch count.
REQ-017 first_exp, first_obs  output  WIDTH each  expected/observed values of first mismatch.
REQ-018 checking  output  1  high while in CHECK.

Function
REQ-019 FSM states IDLE, SYNC, CHECK; IDLE after reset.
REQ-020 IDLE: arm=1 -> SYNC; clear err_sticky, err_count, first_exp, first_obs on that edge.
REQ-021 SYNC: lasts one cycle; seeds predictor by applying next-value rule (REQ-023) to the observed count and current controls; -> CHECK.
REQ-022 CHECK: each edge compares count with exp_count; then exp_count <= next value; stop=1 -> IDLE at that edge, comparison on that edge still performed.
REQ-023 Next-value rule, priority order: dut_rst=1 -> 0; else load=1 -> count_in; else en=1,up=1 -> exp+1 mod 2^WIDTH; else en=1,up=0 -> exp-1 mod 2^WIDTH; else hold.
REQ-024 Wrap: 2^WIDTH-1 up -> 0; 0 down -> 2^WIDTH-1; neither is an error.
REQ-025 Simultaneous dut_rst and load: reset wins; load with en=1: load wins.
REQ-026 Mismatch in CHECK: error=1 on the following cycle (latency 1); err_sticky set; err_count +1 unless all-ones (saturate, no wrap).
REQ-027 first_exp/first_obs captured only when err_sticky is currently 0.
REQ-028 No comparisons, error pulses, or counter updates in IDLE or SYNC; arm outside IDLE ignored.
REQ-029 stop and arm both high in IDLE: arm wins.
REQ-030 exp_count holds its value in IDLE.

Reset
REQ-031 rst=0 at a rising edge: state IDLE; exp_count, err_count, first_exp, first_obs = 0; error, err_sticky, checking = 0.
REQ-032 Reset mid-CHECK aborts immediately; a pending error pulse is dropped.
REQ-033 rst has priority over arm, stop, and all observed inputs.

Structure
REQ-034 Package cnt_chk_pkg holds the state enum (IDLE, SYNC, CHECK) and ERR_W default constant.
REQ-035 Next-value rule lives in sub-module cnt_model (combinational, WIDTH parameter), reusable as a golden model.
REQ-036 Single clock domain; no latches; all outputs registered.

Verification
REQ-037 Reset, arm, dut_rst 4 cycles, then en=1 up=1 for 16 cycles with correct counter -> error never 1, exp_count wraps 15->0, err_count=0.
REQ-038 Down from 0: en=1 up=0, counter 0->15->14 -> no error; exp_count=15 after first step.
REQ-039 Inject count=5 when exp=6 in CHECK -> error pulse next cycle, err_sticky=1, err_count=1, first_exp=6, first_obs=5; second mismatch -> err_count=2, first_* unchanged.
REQ-040 load=1 count_in=9 with en=1 up=1 and dut_rst=1 same cycle -> expected 0; next cycle load only -> expected 9.
REQ-041 ERR_W=2 with persistent mismatch for 6 cycles -> err_count saturates at 3.
REQ-042 rst=0 during CHECK with mismatch pending -> no error pulse, state IDLE, all outputs 0; arm later -> clean check.
